sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO in plain RTL. It replaces the fixed 8-bit/512-deep vendor FIFO IP used for the FIFO bring-up tests.
- Adds configurable width and depth, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) mode, and overflow/underflow error pulses.
- Sits between a producer and a consumer in the same sys_clk domain. It is the team's portable buffering primitive for demo and test designs.

Parameters:
- DATA_W, 8: data width in bits.
- ADDR_W, 9: address width; DEPTH = 2**ADDR_W entries (default 512).
- AF_TH, 2**ADDR_W-4: almost_full asserts when count >= AF_TH. Legal range 1..DEPTH.
- AE_TH, 4: almost_empty asserts when count <= AE_TH. Legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through.

Ports:
- sys_clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset. Assertion is asynchronous; de-assertion is used synchronised to sys_clk.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- wr_full  out  1  FIFO full; writes are rejected.
- almost_full  out  1  count >= AF_TH.
- wr_water_level  out  ADDR_W+1  current entry count.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_W  read data.
- rd_empty  out  1  FIFO empty; reads are rejected.
- almost_empty  out  1  count <= AE_TH.
- rd_water_level  out  ADDR_W+1  current entry count; identical to wr_water_level because there is one clock.
- overflow  out  1  one-cycle pulse when a write is rejected.
- underflow  out  1  one-cycle pulse when a read is rejected.

Behaviour:
- Reset values:
  - wr_ptr, rd_ptr and count = 0.
  - rd_data = 0.
  - rd_empty = 1, wr_full = 0.
  - almost_empty = 1 (count 0 <= AE_TH); almost_full = 0.
  - overflow = 0, underflow = 0.
  - A reset mid-operation discards all contents immediately. The RAM array itself is not cleared.
- Accept rules, evaluated on the cycle-start state:
  - wr_acc = wr_en & ~wr_full.
  - rd_acc = rd_en & ~rd_empty.
  - Rejected requests leave pointers and count unchanged.
  - overflow = wr_en & wr_full, registered: it pulses on the cycle after the attempt.
  - underflow = rd_en & rd_empty, registered the same way.
- Pointers: ADDR_W bits each; wrap naturally from DEPTH-1 to 0. wr_ptr increments on wr_acc; rd_ptr increments on rd_acc.
- Count: ADDR_W+1 bits.
  - Increments on wr_acc & ~rd_acc.
  - Decrements on rd_acc & ~wr_acc.
  - Unchanged when both or neither are accepted.
- Flags are registered and computed from the next count, so they change on the same edge as count:
  - rd_empty = (count==0).
  - wr_full = (count==DEPTH).
  - almost_full = (count>=AF_TH).
  - almost_empty = (count<=AE_TH).
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected (overflow pulse). The write is not allowed to fill the freed slot in the same cycle.
  - When empty: the write is accepted and the read is rejected (underflow pulse). No write-through bypass.
  - Otherwise both are accepted and count holds.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data is loaded with mem[rd_ptr] at the edge, so it is valid on the cycle following the rd_en cycle.
  - rd_data holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally whenever rd_empty=0. It is don't-care (last value) when empty.
  - rd_en acknowledges/pops the head; the next word appears the cycle after the pop.
  - Write-to-visible latency is 1 cycle: a word written at edge N has rd_empty=0 and rd_data valid after edge N.
- Write-to-empty-deassert latency is 1 edge in both modes.
- Elaboration check: AF_TH and AE_TH out of range → $error.

Decomposition:
- Shared package/header fifo_pkg: default DATA_W/ADDR_W, and a function computing DEPTH from ADDR_W.
- One sub-module, sync_fifo_ram: simple dual-port array with a synchronous write port and an asynchronous read port.
- Top-level holds the pointers, count, flags, error pulses and the FWFT/standard output mux.

Test Plan:
- Reset, then write 0x01..0x05 with no reads:
  - wr_water_level = 5 after the 5th edge.
  - rd_empty falls 1 edge after the first write.
  - almost_empty falls when count reaches 5 (AE_TH=4).
- FWFT=0, read 5 times back to back:
  - rd_data = 0x01..0x05 on consecutive cycles, each 1 cycle after its rd_en.
  - rd_empty = 1 after the 5th pop.
  - A 6th rd_en gives underflow = 1 for one cycle and rd_data holds 0x05.
- Fill to 512 entries:
  - almost_full rises at count 508; wr_full rises at 512.
  - An extra write gives overflow = 1 pulse, count stays 512, and the data is not stored.
- Full, with wr_en=1 and rd_en=1 in the same cycle:
  - The read is accepted and the write is rejected; count becomes 511 and overflow = 1.
  - Next cycle, wr_en=1 and rd_en=1 again: count stays 511.
- FWFT=1:
  - Write 0xAA at edge N: rd_data = 0xAA with no rd_en after edge N.
  - rd_en pops it and rd_empty = 1.
  - Pointer wrap: 600 streamed words read back in order with no loss.
- Assert rst_n low mid-stream with count = 200:
  - Immediately count = 0, rd_empty = 1, wr_full = 0, rd_data = 0.
  - Post-reset writes and reads start from address 0.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// Shared defaults, depth helper and the registered status-flag bundle for
// the parametrised single-clock FIFO.
package sync_fifo_param_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 9;

  // Number of entries addressable with addr_w pointer bits.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Status flags, all registered and updated together with the count.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param. The master side
// is the user logic; the slave side is the FIFO itself.
interface sync_fifo_param_if
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_water_level;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_water_level;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_full, almost_full, wr_water_level, rd_data, rd_empty,
           almost_empty, rd_water_level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_full, almost_full, wr_water_level, rd_data, rd_empty,
           almost_empty, rd_water_level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module sync_fifo_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];

  // Write port: store one word per accepted write.
  // NOTE: the array has no reset; stale contents are unreachable because the
  // pointers and count are reset, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost thresholds,
// optional first-word-fall-through output and registered error pulses.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_TH  = fifo_depth(ADDR_W) - 4,
  parameter int AE_TH  = 4,
  parameter int FWFT   = 0
) (
  input logic             sys_clk,
  input logic             rst_n,
  sync_fifo_param_if.slave f
);

  localparam int              DEPTH   = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_TH[ADDR_W:0];

  if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af_th
    $error("sync_fifo_param: AF_TH out of range 1..DEPTH");
  end
  if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_bad_ae_th
    $error("sync_fifo_param: AE_TH out of range 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  fifo_flags_t       flags_q, flags_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rd_data_out;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_acc, rd_acc;

  // Requests are judged against the flags at the start of the cycle, so a
  // read from a full FIFO never lets a simultaneous write into the freed slot.
  assign wr_acc = f.wr_en & ~flags_q.full;
  assign rd_acc = f.rd_en & ~flags_q.empty;

  sync_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (sys_clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (f.wr_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Output mux: FWFT shows the head word whenever data is present, otherwise
  // the registered word from the last accepted read (or last shown word).
  always_comb begin
    rd_data_out = rd_data_q;
    if (FWFT != 0 && !flags_q.empty) rd_data_out = ram_rdata;
  end

  // Next-state: pointers, count, flags from the next count, error pulses.
  // NOTE: every output gets its hold value first, so no path leaves a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    overflow_d  = f.wr_en & flags_q.full;
    underflow_d = f.rd_en & flags_q.empty;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (FWFT != 0)  rd_data_d = rd_data_out;
    else if (rd_acc) rd_data_d = ram_rdata;

    flags_d.empty        = (count_d == '0);
    flags_d.full         = (count_d == DEPTH_C);
    flags_d.almost_empty = (count_d <= AE_C);
    flags_d.almost_full  = (count_d >= AF_C);
  end

  // State registers; reset discards all contents at once.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flags_q     <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign f.wr_full        = flags_q.full;
  assign f.almost_full    = flags_q.almost_full;
  assign f.rd_empty       = flags_q.empty;
  assign f.almost_empty   = flags_q.almost_empty;
  assign f.wr_water_level = count_q;
  assign f.rd_water_level = count_q;
  assign f.overflow       = overflow_q;
  assign f.underflow      = underflow_q;
  assign f.rd_data        = rd_data_out;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT
// instance, a queue-based scoreboard checked by a separate read monitor.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_TH(508), .AE_TH(4), .FWFT(0)) dut0 (
    .sys_clk (sys_clk), .rst_n (rst_n), .f (if0)
  );
  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_TH(508), .AE_TH(4), .FWFT(1)) dut1 (
    .sys_clk (sys_clk), .rst_n (rst_n), .f (if1)
  );

  // Bench-side stimulus, steered to one instance by sel.
  logic          we = 1'b0, re = 1'b0, sel = 1'b0;
  logic [DW-1:0] wd = '0;

  assign if0.wr_en   = we & ~sel;
  assign if0.rd_en   = re & ~sel;
  assign if0.wr_data = wd;
  assign if1.wr_en   = we & sel;
  assign if1.rd_en   = re & sel;
  assign if1.wr_data = wd;

  logic [DW-1:0] o_data;
  logic          o_empty, o_full, o_ae, o_af, o_ovf, o_unf;
  logic [AW:0]   o_lvl, o_rlvl;

  assign o_data  = sel ? if1.rd_data        : if0.rd_data;
  assign o_empty = sel ? if1.rd_empty       : if0.rd_empty;
  assign o_full  = sel ? if1.wr_full        : if0.wr_full;
  assign o_ae    = sel ? if1.almost_empty   : if0.almost_empty;
  assign o_af    = sel ? if1.almost_full    : if0.almost_full;
  assign o_ovf   = sel ? if1.overflow       : if0.overflow;
  assign o_unf   = sel ? if1.underflow      : if0.underflow;
  assign o_lvl   = sel ? if1.wr_water_level : if0.wr_water_level;
  assign o_rlvl  = sel ? if1.rd_water_level : if0.rd_water_level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int mcnt     = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own count
  // and queues accepted write data as the expected read stream.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    bit w_ok, r_ok;
    w_ok = w && (mcnt < DEPTH);
    r_ok = r && (mcnt > 0);
    we = w; wd = d; re = r;
    if (w_ok) exp_q.push_back(d);
    mcnt = mcnt + int'(w_ok) - int'(r_ok);
    @(posedge sys_clk); #1;
  endtask

  task automatic pop_cmp();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underrun: DUT read with no expected data at %0t", $time);
    end else begin
      check("rd_data", 32'(o_data), 32'(exp_q.pop_front()));
      n_pop++;
    end
  endtask

  // Read monitor: standard mode compares the cycle after an accepted read,
  // FWFT compares the head word in the cycle it is popped.
  bit pend = 1'b0;
  always @(negedge sys_clk) begin
    if (!rst_n) pend = 1'b0;
    else if (!sel) begin
      if (pend) pop_cmp();
      pend = re && !o_empty;
    end else if (re && !o_empty) begin
      pop_cmp();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops_before;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;

    // Reset state (standard instance).
    check("rst_empty", 32'(o_empty), 1);
    check("rst_full",  32'(o_full),  0);
    check("rst_ae",    32'(o_ae),    1);
    check("rst_af",    32'(o_af),    0);
    check("rst_lvl",   32'(o_lvl),   0);
    check("rst_ovf",   32'(o_ovf),   0);
    check("rst_unf",   32'(o_unf),   0);
    check("rst_data",  32'(o_data),  0);

    // Write 0x01..0x05.
    cyc(1'b1, 8'h01, 1'b0);
    check("empty_1edge", 32'(o_empty), 0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h04, 1'b0);
    check("ae_at_4", 32'(o_ae), 1);
    cyc(1'b1, 8'h05, 1'b0);
    check("ae_at_5",  32'(o_ae),   0);
    check("wr_lvl_5", 32'(o_lvl),  5);
    check("rd_lvl_5", 32'(o_rlvl), 5);

    // Five back-to-back reads, then one into an empty FIFO.
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    check("empty_after_5", 32'(o_empty), 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("unf_pulse", 32'(o_unf),  1);
    check("unf_hold",  32'(o_data), 8'h05);
    cyc(1'b0, 8'h00, 1'b0);
    check("unf_clear", 32'(o_unf), 0);

    // Fill to 512.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 506) check("af_at_507",  32'(o_af),   0);
      if (i == 507) check("af_at_508",  32'(o_af),   1);
      if (i == 510) check("full_at_511", 32'(o_full), 0);
      if (i == 511) check("full_at_512", 32'(o_full), 1);
    end
    cyc(1'b1, 8'hEE, 1'b0);
    check("ovf_pulse", 32'(o_ovf), 1);
    check("ovf_lvl",   32'(o_lvl), 512);
    cyc(1'b0, 8'h00, 1'b0);
    check("ovf_clear", 32'(o_ovf), 0);

    // Simultaneous write and read while full, then again at 511.
    cyc(1'b1, 8'hEF, 1'b1);
    check("full_rw_lvl", 32'(o_lvl),  511);
    check("full_rw_ovf", 32'(o_ovf),  1);
    check("full_rw_full", 32'(o_full), 0);
    cyc(1'b1, 8'hF0, 1'b1);
    check("rw_511_lvl", 32'(o_lvl), 511);
    check("rw_511_ovf", 32'(o_ovf), 0);

    // Drain to 200 entries, then reset mid-stream.
    while (mcnt > 200) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check("lvl_200", 32'(o_lvl), 200);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_lvl",   32'(o_lvl),   0);
    check("mid_rst_empty", 32'(o_empty), 1);
    check("mid_rst_full",  32'(o_full),  0);
    check("mid_rst_data",  32'(o_data),  0);
    check("mid_rst_wptr",  32'(dut0.wr_ptr_q), 0);
    check("mid_rst_rptr",  32'(dut0.rd_ptr_q), 0);
    exp_q.delete();
    mcnt = 0;
    @(posedge sys_clk); #1 rst_n = 1'b1;

    // Post-reset traffic starts at address 0.
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    check("post_rst_wptr", 32'(dut0.wr_ptr_q), 2);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check("post_rst_rptr", 32'(dut0.rd_ptr_q), 2);

    // FWFT instance.
    sel = 1'b1;
    #1;
    check("fwft_idle_empty", 32'(o_empty), 1);
    cyc(1'b1, 8'hAA, 1'b0);
    check("fwft_empty_n", 32'(o_empty), 0);
    check("fwft_data_aa", 32'(o_data),  8'hAA);
    cyc(1'b0, 8'h00, 1'b1);
    check("fwft_pop_empty", 32'(o_empty), 1);

    // 600 streamed words across the pointer wrap.
    pops_before = n_pop;
    for (int i = 0; i < 600; i++) cyc(1'b1, 8'(i * 7 + 3), mcnt > 0);
    while (mcnt > 0) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check("stream_pops",  32'(n_pop - pops_before), 600);
    check("stream_left",  32'(exp_q.size()), 0);
    check("stream_lvl",   32'(o_lvl), 0);
    check("stream_wptr",  32'(dut1.wr_ptr_q), 89);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
